// File: rtl/tx_scrambler.sv
// Serial frame transmitter: unscrambled SIGNAL header followed by a scrambled
// SERVICE/DATA stream using the x^7 + x^4 + 1 additive scrambler.
module tx_scrambler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [3:0]  rate_in,
  input  logic [11:0] length_in,
  input  logic [6:0]  seed_in,
  input  logic        data_in,
  output logic        data_req,
  output logic        data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2,
    DATA    = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [14:0] cnt_r, cnt_s;
  logic [3:0]  rate_r;
  logic [11:0] len_r;
  logic [6:0]  scr_r, scr_s;  // scr_r[0] = s1 ... scr_r[6] = s7
  logic        data_out_r, data_out_s;
  logic        data_valid_r, data_valid_s;
  logic        done_r, done_s;
  logic        fb_s;
  logic [23:0] sig_s;
  logic [14:0] data_last_s;

  function automatic logic even_parity(input logic [16:0] v);
    return ^v;
  endfunction

  assign fb_s        = scr_r[3] ^ scr_r[6];
  assign sig_s       = {6'b000000, even_parity({len_r, 1'b0, rate_r}), len_r, 1'b0, rate_r};
  assign data_last_s = {len_r, 3'b000} - 15'd1;

  assign data_req   = (state_r == DATA);
  assign busy       = (state_r != IDLE);
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign done       = done_r;

  // Next-state, counter, scrambler and output-bit selection.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    scr_s        = scr_r;
    data_out_s   = 1'b0;
    data_valid_s = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SIGNAL;
          cnt_s   = 15'd0;
          scr_s   = (seed_in == 7'd0) ? 7'h7F : seed_in;
        end else begin
          state_s = IDLE;
        end
      end
      SIGNAL: begin
        data_out_s   = sig_s[cnt_r[4:0]];
        data_valid_s = 1'b1;
        if (cnt_r == 15'd23) begin
          state_s = SERVICE;
          cnt_s   = 15'd0;
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      SERVICE: begin
        data_out_s   = fb_s;
        data_valid_s = 1'b1;
        scr_s        = {scr_r[5:0], fb_s};
        if (cnt_r == 15'd15) begin
          cnt_s = 15'd0;
          // A zero-length frame ends on the last service bit.
          if (len_r == 12'd0) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = DATA;
          end
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      DATA: begin
        data_out_s   = data_in ^ fb_s;
        data_valid_s = 1'b1;
        scr_s        = {scr_r[5:0], fb_s};
        if (cnt_r == data_last_s) begin
          done_s  = 1'b1;
          state_s = IDLE;
          cnt_s   = 15'd0;
        end else begin
          cnt_s = cnt_r + 15'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 15'd0;
      end
    endcase
  end

  // State, counter, scrambler and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      cnt_r        <= 15'd0;
      scr_r        <= 7'd0;
      data_out_r   <= 1'b0;
      data_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      scr_r        <= scr_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
      done_r       <= done_s;
    end
  end

  // Frame parameters are captured at start and need no reset value.
  always_ff @(posedge Clk) begin
    if ((state_r == IDLE) && start) begin
      rate_r <= rate_in;
      len_r  <= length_in;
    end else begin
      rate_r <= rate_r;
      len_r  <= len_r;
    end
  end

endmodule

// File: tb/tb_tx_scrambler.sv
// Randomized scoreboard bench for tx_scrambler with a sequence-level reference
// model and an independent descrambler loopback.
module tb_tx_scrambler;

  logic        Clk = 1'b0;
  logic        Reset, start, data_in;
  logic [3:0]  rate_in;
  logic [11:0] length_in;
  logic [6:0]  seed_in;
  logic        data_req, data_out, data_valid, busy, done;

  int   errors = 0;
  int   checks = 0;
  logic [1:0] exp_q[$];  // {done, bit}
  bit   pay_q[$];
  bit   rx_q[$];
  int   vcnt, rcnt;
  bit   mon_en = 1'b0;

  tx_scrambler dut (
    .Clk(Clk), .Reset(Reset), .start(start), .rate_in(rate_in),
    .length_in(length_in), .seed_in(seed_in), .data_in(data_in),
    .data_req(data_req), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: output n of the keystream is prev4 ^ prev7, history seeded by s7..s1.
  task automatic push_frame(input logic [3:0] rate, input logic [11:0] len,
                            input logic [6:0] seed, input bit pay[$]);
    int   sig[24];
    int   h[];
    int   nscr, par, total, idx, k, b;
    logic [6:0] s;
    for (int i = 0; i < 24; i++) sig[i] = 0;
    for (int i = 0; i < 4; i++) sig[i] = rate[i];
    for (int i = 0; i < 12; i++) sig[5 + i] = len[i];
    par = 0;
    for (int i = 0; i < 17; i++) par += sig[i];
    sig[17] = par % 2;
    nscr  = 16 + 8 * int'(len);
    total = 24 + nscr;
    idx   = 0;
    for (int i = 0; i < 24; i++) begin
      idx++;
      exp_q.push_back({1'b0, sig[i][0]});
    end
    s = (seed == 7'd0) ? 7'h7F : seed;
    h = new[7 + nscr];
    for (int i = 0; i < 7; i++) h[i] = s[6 - i];
    for (int n = 0; n < nscr; n++) begin
      k = h[n + 3] ^ h[n];
      h[n + 7] = k;
      b = (n < 16) ? k : (k ^ int'(pay[n - 16]));
      idx++;
      exp_q.push_back({(idx == total) ? 1'b1 : 1'b0, b[0]});
    end
  endtask

  // Monitor: pops the scoreboard whenever a frame bit is presented.
  always @(negedge Clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (data_req) rcnt++;
      if (data_valid) begin
        vcnt++;
        rx_q.push_back(data_out);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got data_valid=1 expected no frame bit");
        end else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e[0]);
          chk("done_flag", done, e[1]);
        end
      end else begin
        chk("done_idle", done, 1'b0);
      end
    end
  end

  // Payload driver: serves the next payload bit while the DUT requests data.
  always @(negedge Clk) begin
    if (data_req && pay_q.size() > 0) data_in = pay_q.pop_front();
    else data_in = 1'($urandom_range(0, 1));
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still 1 after %0d cycles expected 0", budget);
    end
  endtask

  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len,
                           input logic [6:0] seed, input bit ones, input bit poke_start,
                           input bit chk_gold);
    bit   pay[$];
    bit   gold[40] = '{1,0,1,1,0, 0,0,1,0,0,1,1,0,0,0,0,0, 0, 0,0,0,0,0,0,
                       0,0,0,0,1,1,1,0,1,1,1,1,0,0,1,0};
    int   g[];
    int   mism, k, ndata;
    ndata = 8 * int'(len);
    for (int i = 0; i < ndata; i++) pay.push_back(ones ? 1'b1 : 1'($urandom_range(0, 1)));
    foreach (pay[i]) pay_q.push_back(pay[i]);
    push_frame(rate, len, seed, pay);
    vcnt = 0;
    rcnt = 0;
    rx_q.delete();
    @(negedge Clk);
    start = 1'b1; rate_in = rate; length_in = len; seed_in = seed;
    @(negedge Clk);
    start = 1'b0;
    rate_in = 4'($urandom); length_in = 12'($urandom); seed_in = 7'($urandom);
    chk("busy_after_start", busy, 1'b1);
    if (poke_start) begin
      repeat (8) @(negedge Clk);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
    end
    wait_idle(80 + ndata);
    repeat (3) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("valid_count", vcnt, 40 + ndata);
    chk("req_count", rcnt, ndata);
    if (chk_gold && rx_q.size() >= 40) begin
      mism = 0;
      for (int i = 0; i < 40; i++) if (rx_q[i] != gold[i]) mism++;
      chk("header_golden_mismatches", mism, 0);
    end
    // Descrambler: seed from the last 7 service bits, then strip the keystream.
    if (ndata > 0 && rx_q.size() >= 40 + ndata) begin
      mism = 0;
      g = new[7 + ndata];
      for (int i = 0; i < 7; i++) g[i] = int'(rx_q[33 + i]);
      for (int n = 0; n < ndata; n++) begin
        k = g[n + 3] ^ g[n];
        g[n + 7] = k;
        if ((int'(rx_q[40 + n]) ^ k) != int'(pay[n])) mism++;
      end
      chk("loopback_mismatches", mism, 0);
    end
  endtask

  initial begin
    bit nopay[$];
    Reset = 1'b1; start = 1'b0; rate_in = 4'd0; length_in = 12'd0; seed_in = 7'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_data_out", data_out, 1'b0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", data_req, 1'b0);
    Reset = 1'b0;
    mon_en = 1'b1;

    run_frame(4'b1101, 12'd100, 7'h7F, 1'b0, 1'b0, 1'b1);
    run_frame(4'b1101, 12'd1,   7'h7F, 1'b1, 1'b0, 1'b0);
    run_frame(4'b1101, 12'd0,   7'h00, 1'b0, 1'b1, 1'b0);
    run_frame(4'b0110, 12'd3,   7'h00, 1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++)
      run_frame(4'($urandom), 12'($urandom_range(1, 6)), 7'($urandom), 1'b0, 1'b0, 1'b0);
    run_frame(4'b1101, 12'd3, 7'h7F, 1'b0, 1'b0, 1'b0);

    // start held high through done: ignored at the done edge, accepted next cycle.
    push_frame(4'b1010, 12'd0, 7'h35, nopay);
    push_frame(4'b1010, 12'd0, 7'h35, nopay);
    vcnt = 0;
    @(negedge Clk);
    start = 1'b1; rate_in = 4'b1010; length_in = 12'd0; seed_in = 7'h35;
    @(negedge Clk);
    wait_idle(100);
    @(negedge Clk);
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    wait_idle(100);
    repeat (3) @(negedge Clk);
    chk("restart_queue", exp_q.size(), 0);
    chk("restart_valid", vcnt, 80);

    // Abort in the fifth DATA cycle.
    @(negedge Clk);
    start = 1'b1; rate_in = 4'b0011; length_in = 12'd3; seed_in = 7'h11;
    @(negedge Clk);
    start = 1'b0;
    mon_en = 1'b0;
    for (int n = 0; n < 200 && !data_req; n++) @(negedge Clk);
    chk("reached_data", data_req, 1'b1);
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.delete();
    pay_q.delete();
    chk("abort_data_out", data_out, 1'b0);
    chk("abort_valid", data_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_req", data_req, 1'b0);
    repeat (3) begin
      @(negedge Clk);
      chk("abort_no_done", done, 1'b0);
    end
    mon_en = 1'b1;
    run_frame(4'b1101, 12'd2, 7'h5A, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
